// File: rtl/uart_tx_pkg.sv
// Shared types and sizing helpers for the FIFO-to-UART transmit sequencer.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_e;

    function automatic int unsigned nbytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned idx_width(input int unsigned data_w);
        return (nbytes(data_w) > 1) ? $clog2(nbytes(data_w)) : 1;
    endfunction

    // Counter runs 0..RD_LAT-1 across the WAIT state.
    function automatic int unsigned lat_cnt_width(input int unsigned rd_lat);
        return (rd_lat > 1) ? $clog2(rd_lat) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_word_serializer.sv
// Holds the popped word and byte index; presents the byte selected by the
// next-state index so the top can register it alongside o_tx_valid.
module uart_tx_word_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [7:0]        byte_d_o,
    output logic              last_o
);

    localparam int unsigned NB = nbytes(DATA_W);
    localparam int unsigned IW = idx_width(DATA_W);

    logic [DATA_W-1:0] word_q, word_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     sel;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load_i) begin
            word_d = data_i;
            idx_d  = '0;
        end else if (advance_i) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign sel      = MSB_FIRST ? (IW'(NB - 1) - idx_d) : idx_d;
    assign byte_d_o = word_d[8*sel +: 8];
    assign last_o   = (idx_q == IW'(NB - 1));

endmodule

// File: rtl/uart_tx_stream_ctrl.sv
// FIFO-to-UART transmit sequencer: pops a word once the FIFO threshold (or
// flush) allows it, then hands its bytes to the UART one handshake at a time.
module uart_tx_stream_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MIN_LEVEL = 2,
    parameter int unsigned RD_LAT    = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_fifo_empty,
    input  logic [CNT_W-1:0]  i_fifo_level,
    input  logic [DATA_W-1:0] i_fifo_rd_data,
    output logic              o_fifo_rd_en,
    input  logic              i_flush,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    input  logic              i_tx_done,
    output logic              o_busy
);

    localparam int unsigned CW = lat_cnt_width(RD_LAT);
    localparam int unsigned LW = (CNT_W > 32) ? CNT_W + 1 : 33;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start;
    logic            load;
    logic            advance;
    logic            last;
    logic [7:0]      byte_d;
    logic            rd_en_q;
    logic            valid_q;
    logic            busy_q;
    logic [7:0]      data_q;

    // Widened compare so a large MIN_LEVEL can never alias a small level.
    assign start = !i_fifo_empty &&
                   ((LW'(i_fifo_level) >= LW'(MIN_LEVEL)) || i_flush);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_READ;
            ST_READ: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    state_d = ST_SEND;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND: if (i_tx_ready) state_d = ST_DONE;
            ST_DONE: begin
                if (i_tx_done) begin
                    if (!last) begin
                        advance = 1'b1;
                        state_d = ST_SEND;
                    end else if (start) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_en_q <= (state_d == ST_READ);
            valid_q <= (state_d == ST_SEND);
            busy_q  <= (state_d != ST_IDLE);
            data_q  <= (state_d == ST_SEND) ? byte_d : '0;
        end
    end

    uart_tx_word_serializer #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_ser (
        .clk_i     (i_clk),
        .rst_ni    (i_rstn),
        .load_i    (load),
        .advance_i (advance),
        .data_i    (i_fifo_rd_data),
        .byte_d_o  (byte_d),
        .last_o    (last)
    );

    assign o_fifo_rd_en = rd_en_q;
    assign o_tx_valid   = valid_q;
    assign o_tx_data    = data_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_stream_ctrl.sv
// Two instances (32-bit LSB-first RD_LAT=1, 16-bit MSB-first RD_LAT=3) checked
// every cycle against a timestamp/queue model of the byte stream.
module tb_uart_tx_stream_ctrl;

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned MIN_LEVEL = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int unsigned ready_pct  = 100;
    int unsigned spur_pct   = 0;
    int unsigned push_pct   = 0;
    int unsigned done_fixed = 10;
    logic        push_req   = 1'b0;
    logic [31:0] push_word  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : env
        localparam int unsigned DW  = (g == 0) ? 32 : 16;
        localparam int unsigned RL  = (g == 0) ? 1 : 3;
        localparam bit          MSB = (g == 1);
        localparam int unsigned NB  = DW / 8;

        logic             fifo_empty = 1'b1;
        logic [CNT_W-1:0] fifo_level = '0;
        logic [DW-1:0]    rd_data    = '0;
        logic             tx_ready   = 1'b0;
        logic             tx_done    = 1'b0;
        logic             rd_en;
        logic             tx_valid;
        logic             busy;
        logic [7:0]       tx_data;

        logic [DW-1:0] fifo_q[$];
        logic [DW-1:0] pipe_w[$];
        longint        pipe_due[$];
        logic [7:0]    bytes_q[$];
        bit            active    = 1'b0;
        bit            awaiting  = 1'b0;
        bit            last_wait = 1'b0;
        bit            presenting;
        bit            start;
        longint        cyc        = 0;
        longint        pop_at     = -1;
        longint        present_at = -1;
        longint        done_due   = -1;

        uart_tx_stream_ctrl #(
            .DATA_W    (DW),
            .CNT_W     (CNT_W),
            .MIN_LEVEL (MIN_LEVEL),
            .RD_LAT    (RL),
            .MSB_FIRST (MSB)
        ) u_dut (
            .i_clk          (clk),
            .i_rstn         (rstn),
            .i_fifo_empty   (fifo_empty),
            .i_fifo_level   (fifo_level),
            .i_fifo_rd_data (rd_data),
            .o_fifo_rd_en   (rd_en),
            .i_flush        (flush),
            .o_tx_data      (tx_data),
            .o_tx_valid     (tx_valid),
            .i_tx_ready     (tx_ready),
            .i_tx_done      (tx_done),
            .o_busy         (busy)
        );

        task automatic launch();
            logic [DW-1:0] w;
            active     = 1'b1;
            pop_at     = cyc + 1;
            present_at = cyc + 2 + longint'(RL);
            w          = fifo_q[0];
            for (int k = 0; k < int'(NB); k++)
                bytes_q.push_back(8'(w >> (8 * (MSB ? (int'(NB) - 1 - k) : k))));
        endtask

        task automatic do_pushes();
            if (push_req && fifo_q.size() < 200) fifo_q.push_back(DW'(push_word));
            if ($urandom_range(99) < push_pct && fifo_q.size() < 200)
                fifo_q.push_back(DW'($urandom));
            fifo_level = CNT_W'(fifo_q.size());
            fifo_empty = (fifo_q.size() == 0);
        endtask

        always @(negedge clk) begin
            cyc++;
            if (!rstn) begin
                chk($sformatf("e%0d rst rd_en", g), 32'(rd_en), 32'd0);
                chk($sformatf("e%0d rst valid", g), 32'(tx_valid), 32'd0);
                chk($sformatf("e%0d rst data", g), 32'(tx_data), 32'd0);
                chk($sformatf("e%0d rst busy", g), 32'(busy), 32'd0);
                active     = 1'b0;
                awaiting   = 1'b0;
                last_wait  = 1'b0;
                pop_at     = -1;
                present_at = -1;
                bytes_q.delete();
                pipe_w.delete();
                pipe_due.delete();
                tx_ready = 1'($urandom_range(1));
                tx_done  = 1'($urandom_range(1));
                rd_data  = DW'($urandom);
                do_pushes();
            end else begin
                presenting = active && (bytes_q.size() > 0) && !awaiting && (cyc >= present_at);
                chk($sformatf("e%0d rd_en", g), 32'(rd_en), 32'(cyc == pop_at));
                chk($sformatf("e%0d valid", g), 32'(tx_valid), 32'(presenting));
                chk($sformatf("e%0d data", g), 32'(tx_data), presenting ? 32'(bytes_q[0]) : 32'd0);
                chk($sformatf("e%0d busy", g), 32'(busy), 32'(active));

                if (rd_en && fifo_q.size() > 0) begin
                    pipe_w.push_back(fifo_q.pop_front());
                    pipe_due.push_back(cyc + longint'(RL));
                end
                rd_data = DW'($urandom);
                if (pipe_due.size() > 0 && pipe_due[0] == cyc) begin
                    rd_data = pipe_w.pop_front();
                    void'(pipe_due.pop_front());
                end
                do_pushes();

                tx_ready = ($urandom_range(99) < ready_pct);
                if (awaiting) tx_done = (cyc == done_due);
                else          tx_done = ($urandom_range(99) < spur_pct);

                start = (fifo_q.size() > 0) && ((fifo_q.size() >= int'(MIN_LEVEL)) || flush);

                if (awaiting && tx_done) begin
                    void'(bytes_q.pop_front());
                    awaiting = 1'b0;
                    if (bytes_q.size() > 0) present_at = cyc + 1;
                    else if (start)         launch();
                    else                    active = 1'b0;
                end else if (!active && start) begin
                    launch();
                end
                if (presenting && tx_ready) begin
                    awaiting = 1'b1;
                    done_due = cyc + longint'((done_fixed != 0) ? done_fixed : $urandom_range(6, 1));
                end
                last_wait = awaiting && (bytes_q.size() == 1);
            end
        end
    end

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] w);
        push_word = w;
        push_req  = 1'b1;
        wait_cyc(1);
        push_req  = 1'b0;
    endtask

    initial begin
        bit hit;
        wait_cyc(3);
        rstn = 1'b1;

        // Two words: level reaches 2, first word streams out, second stays put.
        push(32'h4433_2211);
        push(32'h8877_A55A);
        wait_cyc(120);

        // Level 1 below threshold: nothing pops until flush, flush dropped mid-word.
        wait_cyc(100);
        flush = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (env[0].rd_en) hit = 1'b1;
            else wait_cyc(1);
        end
        chk("flush_pop_seen", 32'(hit), 32'd1);
        wait_cyc(6);
        flush = 1'b0;
        wait_cyc(150);

        // Ready held low while valid is up, spurious done pulses throughout.
        ready_pct = 0;
        spur_pct  = 50;
        push(32'hDEAD_BEEF);
        push(32'h0BAD_F00D);
        wait_cyc(25);
        ready_pct  = 100;
        spur_pct   = 0;
        done_fixed = 0;
        wait_cyc(80);

        // Back-to-back words.
        done_fixed = 3;
        for (int i = 0; i < 5; i++) push($urandom);
        wait_cyc(200);

        // Random traffic.
        done_fixed = 0;
        push_pct   = 10;
        spur_pct   = 20;
        for (int i = 0; i < 60; i++) begin
            ready_pct = $urandom_range(100, 20);
            if ($urandom_range(3) == 0) flush = ~flush;
            wait_cyc(50);
        end
        flush = 1'b0;

        // Reset while the 16-bit instance waits for the done of byte 1.
        ready_pct  = 100;
        spur_pct   = 0;
        done_fixed = 5;
        push_pct   = 20;
        hit = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            if (env[1].last_wait) hit = 1'b1;
            else wait_cyc(1);
        end
        chk("rst_point_reached", 32'(hit), 32'd1);
        rstn = 1'b0;
        #1;
        chk("async e0 rd_en", 32'(env[0].rd_en), 32'd0);
        chk("async e0 valid", 32'(env[0].tx_valid), 32'd0);
        chk("async e0 data", 32'(env[0].tx_data), 32'd0);
        chk("async e0 busy", 32'(env[0].busy), 32'd0);
        chk("async e1 rd_en", 32'(env[1].rd_en), 32'd0);
        chk("async e1 valid", 32'(env[1].tx_valid), 32'd0);
        chk("async e1 data", 32'(env[1].tx_data), 32'd0);
        chk("async e1 busy", 32'(env[1].busy), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        wait_cyc(200);

        // Drain.
        push_pct = 0;
        flush    = 1'b1;
        wait_cyc(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_stream_ctrl.md
# uart_tx_stream_ctrl

Parametrised FIFO-to-UART transmit sequencer. It sits between the read side of the TX data FIFO and the UART transmitter core. It pops words of configurable width once a fill threshold is met, or unconditionally in flush mode, and splits each word into bytes. Bytes go to the UART over a valid/ready handshake, and the block waits for a per-byte done pulse before presenting the next byte.

## Interface
Parameters:
- DATA_W, 32: FIFO word width; multiple of 8, range 8..64; NB = DATA_W/8 bytes per word.
- CNT_W, 8: width of FIFO level input.
- MIN_LEVEL, 2: minimum FIFO level (unsigned, ≥1) to start a word in normal mode.
- RD_LAT, 1: FIFO read latency in cycles from rd_en to valid data; ≥1.
- MSB_FIRST, 0: 0 = byte [7:0] sent first; 1 = byte [DATA_W-1:DATA_W-8] first.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_level  in  CNT_W  FIFO occupancy, unsigned.
- i_fifo_rd_data  in  DATA_W  FIFO read data, valid RD_LAT cycles after o_fifo_rd_en.
- o_fifo_rd_en  out  1  one-cycle FIFO pop strobe.
- i_flush  in  1  level-sensitive drain mode; ignores MIN_LEVEL.
- o_tx_data  out  8  byte to UART.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  UART accepts byte when o_tx_valid && i_tx_ready.
- i_tx_done  in  1  one-cycle pulse: accepted byte fully shifted out.
- o_busy  out  1  high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE → READ when !i_fifo_empty && (i_fifo_level ≥ MIN_LEVEL || i_flush).
  - READ, one cycle, o_fifo_rd_en=1 → WAIT.
  - WAIT, RD_LAT cycles; captures i_fifo_rd_data into the word register on its last cycle and clears the byte index → SEND.
  - SEND holds o_tx_valid=1 until handshake → DONE.
  - DONE waits for i_tx_done, then:
    - if byte index < NB-1, increment the index → SEND;
    - else, if the start condition holds → READ;
    - else → IDLE.
- Byte select: index k gives byte k (LSB first) or byte NB-1-k (MSB_FIRST=1).
- Outputs are registered and decoded from the next state; no combinational input-to-output paths.
- The threshold comparison uses the full CNT_W width, unsigned; no wrap.
- i_flush is sampled only at word boundaries, in IDLE and at the end of DONE. Deasserting it mid-word does not abort the word.
- i_tx_done is ignored in every state except DONE. i_tx_ready is ignored outside SEND.
- A FIFO empty flag during WAIT/SEND/DONE has no effect; the word is already popped.
- Popped words are never dropped except by reset.

## Timing
- Reset values:
  - o_fifo_rd_en=0, o_tx_valid=0, o_tx_data=8'h00, o_busy=0, state IDLE, word register 0, byte index 0.
  - Asserting reset mid-word discards the word and clears all outputs asynchronously.
- Start condition true in IDLE at cycle N:
  - o_fifo_rd_en=1 in cycle N+1 only;
  - data captured at the end of cycle N+1+RD_LAT;
  - o_tx_valid=1 with byte 0 from cycle N+2+RD_LAT.
- Handshake:
  - o_tx_valid and o_tx_data stay stable until the cycle with i_tx_ready=1, inclusive;
  - o_tx_valid=0 in the following cycle.
- Next byte: i_tx_done in cycle M (in DONE) → next byte valid in cycle M+1.
- Word-to-word: last byte's i_tx_done in cycle M with the start condition true → o_fifo_rd_en in cycle M+1; IDLE is skipped.
- o_fifo_rd_en is never high in two consecutive cycles. At most one word is in flight.

## Structure
- Package uart_tx_pkg holds:
  - state enum (IDLE, READ, WAIT, SEND, DONE), 3 bits;
  - function nbytes(DATA_W) and byte-index width clog2(NB), minimum 1;
  - RD_LAT counter width.
- Sub-module uart_tx_word_serializer: word register, byte index, MSB_FIRST byte mux; load/advance controls driven by the FSM.

## Test plan
- DATA_W=32, MIN_LEVEL=2, RD_LAT=1: level=2, word 0x44332211, ready always high, done 10 cycles after each handshake → bytes 11,22,33,44 in order; rd_en one pulse; valid first high 3 cycles after start.
- MSB_FIRST=1, DATA_W=16, word 0xA55A → bytes A5 then 5A.
- Level=1, MIN_LEVEL=2, flush=0 → no rd_en for 100 cycles; raise flush → word popped and sent; flush dropped mid-word → word completes, no further pop.
- Ready held low 7 cycles in SEND → valid/data stable all 7 cycles; spurious i_tx_done pulses in SEND and IDLE ignored.
- Level=5, back-to-back: last done of word 1 → rd_en next cycle, no IDLE cycle, o_busy stays 1.
- RD_LAT=3; assert reset during DONE of byte 1 → all outputs 0 immediately; after release, next start re-pops a fresh word beginning at byte 0.
